laser_host: RTL and testbench
=============================

# laser_host

Stimulus/scoring front end for the LASER circle-placement engine. It buffers one frame of OBJ_NUM target points from a host loader, resets the engine, and streams the points on X/Y in the engine's fixed read window. It then waits for DONE, captures the two returned centres and scores the result by counting targets covered by the union of both circles. It is the driving and receiving end of the engine's point/centre interface, used in bring-up and in the regression harness.

## Interface

Parameters:
- OBJ_NUM, 40, points per frame
- R2, 16, squared radius; a point is covered when dx²+dy² ≤ R2
- TIMEOUT, 4095, max WAIT cycles before error

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- LD_VALID  in  1  loader point valid
- LD_X  in  4  loader point x
- LD_Y  in  4  loader point y
- LD_READY  out  1  buffer accepts a point
- START  in  1  run one frame (single-cycle pulse)
- LRST  out  1  engine reset
- X  out  4  point x to engine
- Y  out  4  point y to engine
- DONE  in  1  engine result strobe
- C1X, C1Y, C2X, C2Y  in  4 each  engine centres, valid only while DONE=1
- BUSY  out  1  frame in progress (state ≠ IDLE)
- SCORE  out  6  covered-target count, held until next REPORT
- SCORE_VALID  out  1  one-cycle score strobe
- ERR  out  1  set on timeout, cleared on next accepted START

## Operation

- States: IDLE, RSTDUT, STREAM, WAIT, SCORE, REPORT.
- Loading, IDLE only: LD_READY = (wr_ptr < OBJ_NUM). A write occurs when LD_VALID && LD_READY: mem[wr_ptr] ← {LD_Y, LD_X}, then wr_ptr++. The buffer is full when wr_ptr == OBJ_NUM. LD_VALID with LD_READY=0 is ignored.
- IDLE→RSTDUT when START && full. START is ignored if the buffer is not full or the state is not IDLE. A START in the same cycle as the 40th write is ignored, because full is registered.
- RSTDUT: LRST=1 for exactly one cycle, then STREAM.
- STREAM: cnt runs 0..OBJ_NUM-1 and {Y,X} = mem[cnt] each cycle. After the last point, go to WAIT. X=Y=0 in every other state.
- WAIT: the timer counts up from 0.
  - DONE=1: capture all four centres in the DONE cycle, then go to SCORE.
  - timer == TIMEOUT-1 without DONE: set ERR, force SCORE=0, go to REPORT.
  - DONE and expiry in the same cycle: DONE wins.
- DONE outside WAIT is ignored.
- SCORE: one point per cycle, k = 0..OBJ_NUM-1. acc += cover(mem[k], C1) | cover(mem[k], C2). Then go to REPORT.
- cover rule: dx=|px−cx| and dy=|py−cy| are 4-bit; compute dx²+dy² in 8 bits and compare ≤ R2. Example: (dx,dy)=(2,3) is covered; (3,3) and (4,1) are not.
- REPORT: SCORE ← acc, SCORE_VALID=1, wr_ptr ← 0 (the buffer must be reloaded), then IDLE.
- LRST = RST | (state==RSTDUT), so the engine is held in reset while RST is asserted.

## Timing

- Reset values: state IDLE, wr_ptr 0, LD_READY 1, LRST 1 while RST is asserted and 0 after, X=Y=0, BUSY 0, SCORE 0, SCORE_VALID 0, ERR 0. mem is not reset.
- START accepted at cycle n:
  - LRST=1 at n+1.
  - Point k is on X/Y at n+2+k; the engine samples it at the end of that cycle.
  - WAIT begins at n+2+OBJ_NUM.
- DONE at cycle d: SCORE occupies d+1..d+OBJ_NUM and SCORE_VALID fires at d+OBJ_NUM+1.
- Timeout: SCORE_VALID fires at w+TIMEOUT+1, where w is the first WAIT cycle.
- Reset mid-frame: immediate return to IDLE and wr_ptr=0. A partial score is never reported.

## Structure

- Package laser_pkg holds OBJ_NUM, R2, the state enum, and the point typedef (packed {y[3:0], x[3:0]}).
- Sub-module laser_cover_check is purely combinational: point, centre → covered. Instantiate it twice, once for C1 and once for C2.

## Test plan

- Load 40× (5,5); model engine returns C1=(5,5), C2=(0,0) → SCORE=40, ERR=0, SCORE_VALID exactly d+41.
- Points (7,7),(9,10),(10,10),(11,8) plus 36× (0,15); C1=C2=(7,7) → SCORE=2 (the (2,3) offset is covered; (3,3) and (4,1) are not).
- Check X/Y against the buffer for all 40 stream cycles, with LRST high for exactly one cycle before them; START with 39 points loaded → no LRST, BUSY stays 0.
- Engine never asserts DONE → ERR=1, SCORE=0 and SCORE_VALID at w+TIMEOUT+1; next START clears ERR.
- Assert RST at STREAM cnt=20 → IDLE next cycle, LD_READY=1, LRST=1 during reset, no SCORE_VALID afterwards.
- DONE pulse during STREAM is ignored; the frame completes with the correct score.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared constants and types for the LASER host front end.
package laser_pkg;

    localparam int OBJ_NUM = 40;
    localparam int R2      = 16;
    localparam int TIMEOUT = 4095;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSTDUT,
        ST_STREAM,
        ST_WAIT,
        ST_SCORE,
        ST_REPORT
    } state_t;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } point_t;

endpackage

// File: rtl/laser_host_if.sv
// Loader and engine point/centre bus; master is the host front end, slave is loader + engine.
interface laser_host_if;

    logic       LD_VALID;
    logic [3:0] LD_X;
    logic [3:0] LD_Y;
    logic       LD_READY;

    logic       LRST;
    logic [3:0] X;
    logic [3:0] Y;
    logic       DONE;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;

    modport master (
        input  LD_VALID, LD_X, LD_Y,
        output LD_READY,
        output LRST, X, Y,
        input  DONE, C1X, C1Y, C2X, C2Y
    );

    modport slave (
        output LD_VALID, LD_X, LD_Y,
        input  LD_READY,
        input  LRST, X, Y,
        output DONE, C1X, C1Y, C2X, C2Y
    );

endinterface

// File: rtl/laser_cover_check.sv
// Combinational coverage test: is the point within radius sqrt(R2) of the centre.
module laser_cover_check #(
    parameter int R2 = laser_pkg::R2
) (
    input  laser_pkg::point_t point,
    input  laser_pkg::point_t centre,
    output logic              covered
);
    import laser_pkg::*;

    localparam logic [7:0] R2_8 = 8'(R2);

    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] dx8;
    logic [7:0] dy8;
    logic [7:0] dist2;

    // The sum deliberately wraps at 8 bits, matching the engine's own arithmetic.
    always_comb begin
        dx    = (point.x > centre.x) ? (point.x - centre.x) : (centre.x - point.x);
        dy    = (point.y > centre.y) ? (point.y - centre.y) : (centre.y - point.y);
        dx8   = {4'd0, dx};
        dy8   = {4'd0, dy};
        dist2 = dx8 * dx8 + dy8 * dy8;
    end

    assign covered = (dist2 <= R2_8);

endmodule

// File: rtl/laser_host.sv
// Buffers a frame of target points, drives the LASER engine and scores the returned centres.
module laser_host #(
    parameter int OBJ_NUM = laser_pkg::OBJ_NUM,
    parameter int R2      = laser_pkg::R2,
    parameter int TIMEOUT = laser_pkg::TIMEOUT
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    output logic                BUSY,
    output logic [5:0]          SCORE,
    output logic                SCORE_VALID,
    output logic                ERR,
    laser_host_if.master        bus
);
    import laser_pkg::*;

    localparam int PW = $clog2(OBJ_NUM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] LAST = PW'(OBJ_NUM - 1);
    localparam logic [PW-1:0] FULL = PW'(OBJ_NUM);

    state_t            state_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     cnt_reg;
    logic [PW-1:0]     rd_addr;
    logic [TW-1:0]     timer_reg;
    logic              expired_reg;
    point_t [1:0]      centre_reg;
    point_t            rd_reg;
    logic [5:0]        acc_reg;
    logic [5:0]        acc_next;
    logic [5:0]        score_reg;
    logic              score_valid_reg;
    logic              err_reg;
    logic [1:0]        hit;
    logic              full;
    logic              wr_en;

    point_t mem [OBJ_NUM];

    assign full         = (wr_ptr_reg == FULL);
    assign bus.LD_READY = (state_reg == ST_IDLE) && (wr_ptr_reg < FULL);
    assign wr_en        = bus.LD_VALID && bus.LD_READY;

    // Read address runs one ahead of cnt so the registered read lines up with cnt.
    always_comb begin
        rd_addr = '0;
        if ((state_reg == ST_STREAM || state_reg == ST_SCORE) && cnt_reg != LAST) begin
            rd_addr = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= '{y: bus.LD_Y, x: bus.LD_X};
        end
        rd_reg <= mem[rd_addr];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cover
        laser_cover_check #(.R2(R2)) u_cover (
            .point   (rd_reg),
            .centre  (centre_reg[gi]),
            .covered (hit[gi])
        );
    end

    assign acc_next = acc_reg + {5'd0, |hit};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            cnt_reg         <= '0;
            timer_reg       <= '0;
            expired_reg     <= 1'b0;
            centre_reg      <= '0;
            acc_reg         <= '0;
            score_reg       <= '0;
            score_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            score_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (START && full) begin
                        err_reg   <= 1'b0;
                        state_reg <= ST_RSTDUT;
                    end
                end
                ST_RSTDUT: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (cnt_reg == LAST) begin
                        cnt_reg     <= '0;
                        timer_reg   <= '0;
                        expired_reg <= 1'b0;
                        state_reg   <= ST_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Expiry is registered, so the last WAIT cycle is w+TIMEOUT and DONE still wins there.
                    timer_reg   <= timer_reg + 1'b1;
                    expired_reg <= (timer_reg == TW'(TIMEOUT - 1));
                    if (bus.DONE) begin
                        centre_reg[0] <= '{y: bus.C1Y, x: bus.C1X};
                        centre_reg[1] <= '{y: bus.C2Y, x: bus.C2X};
                        acc_reg       <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= ST_SCORE;
                    end else if (expired_reg) begin
                        err_reg         <= 1'b1;
                        score_reg       <= '0;
                        score_valid_reg <= 1'b1;
                        state_reg       <= ST_REPORT;
                    end
                end
                ST_SCORE: begin
                    acc_reg <= acc_next;
                    if (cnt_reg == LAST) begin
                        score_reg       <= acc_next;
                        score_valid_reg <= 1'b1;
                        state_reg       <= ST_REPORT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_REPORT: begin
                    wr_ptr_reg <= '0;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.LRST    = RST | (state_reg == ST_RSTDUT);
    assign bus.X       = (state_reg == ST_STREAM) ? rd_reg.x : 4'd0;
    assign bus.Y       = (state_reg == ST_STREAM) ? rd_reg.y : 4'd0;
    assign BUSY        = (state_reg != ST_IDLE);
    assign SCORE       = score_reg;
    assign SCORE_VALID = score_valid_reg;
    assign ERR         = err_reg;

endmodule

// File: tb/tb_laser_host.sv
// Randomized bench for laser_host with a cycle-timeline reference model.
module tb_laser_host;

    localparam int N   = 40;
    localparam int R2  = 16;
    localparam int TMO = 4095;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       BUSY;
    logic [5:0] SCORE;
    logic       SCORE_VALID;
    logic       ERR;

    laser_host_if bus();

    laser_host #(.OBJ_NUM(N), .R2(R2), .TIMEOUT(TMO)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .BUSY        (BUSY),
        .SCORE       (SCORE),
        .SCORE_VALID (SCORE_VALID),
        .ERR         (ERR),
        .bus         (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Reference arithmetic: squared distance taken modulo 256, then compared with R2.
    function automatic bit cov(input int px, input int py, input int cx, input int cy);
        int dx = (px > cx) ? px - cx : cx - px;
        int dy = (py > cy) ? py - cy : cy - py;
        return ((dx * dx + dy * dy) % 256) <= R2;
    endfunction

    function automatic int score_of(input logic [7:0] p [N], input int c1x, input int c1y,
                                    input int c2x, input int c2y);
        int s = 0;
        for (int k = 0; k < N; k++) begin
            if (cov(int'(p[k][3:0]), int'(p[k][7:4]), c1x, c1y) ||
                cov(int'(p[k][3:0]), int'(p[k][7:4]), c2x, c2y))
                s++;
        end
        return s;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    int         fr_n   = -1;
    int         rep_c  = -1;
    int         rep_s  = 0;
    bit         rep_e  = 1'b0;
    int         loaded = 0;
    int         score_m = 0;
    bit         err_m  = 1'b0;
    logic [7:0] tbuf [N];

    always @(negedge CLK) begin
        int         c;
        bit         busy_m, ready_m, lrst_m, sv_m;
        logic [7:0] xy_m;
        c = cyc;
        if (RST) begin
            fr_n = -1; loaded = 0; score_m = 0; err_m = 1'b0;
            chk("rst_lrst", bus.LRST, 1);
            chk("rst_x", bus.X, 0);
            chk("rst_y", bus.Y, 0);
            chk("rst_busy", BUSY, 0);
            chk("rst_sv", SCORE_VALID, 0);
            chk("rst_score", SCORE, 0);
            chk("rst_err", ERR, 0);
            chk("rst_ready", bus.LD_READY, 1);
        end else begin
            busy_m  = (fr_n >= 0) && (c > fr_n);
            lrst_m  = (fr_n >= 0) && (c == fr_n + 1);
            xy_m    = ((fr_n >= 0) && c >= fr_n + 2 && c < fr_n + 2 + N) ? tbuf[c - fr_n - 2] : 8'h00;
            sv_m    = (fr_n >= 0) && (c == rep_c);
            if (sv_m) begin
                score_m = rep_s;
                if (rep_e) err_m = 1'b1;
            end
            ready_m = !busy_m && (loaded < N);
            chk("lrst", bus.LRST, lrst_m);
            chk("x", bus.X, xy_m[3:0]);
            chk("y", bus.Y, xy_m[7:4]);
            chk("busy", BUSY, busy_m);
            chk("score_valid", SCORE_VALID, sv_m);
            chk("score", SCORE, score_m);
            chk("err", ERR, err_m);
            chk("ld_ready", bus.LD_READY, ready_m);
            // Advance the model with this cycle's inputs.
            if (!busy_m) begin
                if (bus.LD_VALID && ready_m) begin
                    tbuf[loaded] = {bus.LD_Y, bus.LD_X};
                    loaded++;
                end else if (START && loaded == N) begin
                    fr_n = c; rep_c = -1; err_m = 1'b0;
                end
            end else if (rep_c < 0 && c >= fr_n + 2 + N) begin
                if (bus.DONE) begin
                    rep_c = c + N + 1;
                    rep_s = score_of(tbuf, int'(bus.C1X), int'(bus.C1Y), int'(bus.C2X), int'(bus.C2Y));
                    rep_e = 1'b0;
                end else if (c == fr_n + 2 + N + TMO) begin
                    rep_c = c + 1; rep_s = 0; rep_e = 1'b1;
                end
            end else if (c == rep_c) begin
                fr_n = -1; loaded = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pts [N];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_centres();
        bus.C1X = 4'($urandom_range(0, 15));
        bus.C1Y = 4'($urandom_range(0, 15));
        bus.C2X = 4'($urandom_range(0, 15));
        bus.C2Y = 4'($urandom_range(0, 15));
    endtask

    task automatic load(input int first, input int cnt, input bit start_last);
        int i = first;
        while (i < first + cnt) begin
            bus.DONE = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                bus.LD_VALID = 1'b1;
                bus.LD_X = pts[i][3:0];
                bus.LD_Y = pts[i][7:4];
                START = start_last && (i == first + cnt - 1);
                i++;
            end else begin
                bus.LD_VALID = 1'b0;
                bus.LD_X = 4'($urandom_range(0, 15));
                START = 1'b0;
            end
            tick();
        end
        START = 1'b0;
        if (first + cnt == N) begin
            bus.LD_VALID = 1'b1;
            bus.LD_X = 4'($urandom_range(0, 15));
            bus.LD_Y = 4'($urandom_range(0, 15));
            tick();
        end
        bus.LD_VALID = 1'b0;
        bus.DONE = 1'b0;
    endtask

    task automatic run_frame(input int c1x, input int c1y, input int c2x, input int c2y,
                             input int delay, input bit no_done, input bit glitch);
        int n;
        bit seen;
        bus.DONE = 1'b0;
        START = 1'b1;
        n = cyc;
        tick();
        START = 1'b0;
        while (cyc < n + 2 + N + delay) begin
            bus.DONE = glitch && (cyc == n + 10);
            rand_centres();
            tick();
        end
        bus.DONE = 1'b0;
        if (!no_done) begin
            bus.DONE = 1'b1;
            bus.C1X = 4'(c1x); bus.C1Y = 4'(c1y);
            bus.C2X = 4'(c2x); bus.C2Y = 4'(c2y);
            tick();
            bus.DONE = 1'b0;
            rand_centres();
        end
        seen = 1'b0;
        for (int i = 0; i < TMO + 2 * N + 10 && !seen; i++) begin
            if (SCORE_VALID) seen = 1'b1;
            else tick();
        end
        chk("score_valid_seen", seen, 1);
        tick();
    endtask

    initial begin
        bus.LD_VALID = 1'b0; bus.LD_X = 4'd0; bus.LD_Y = 4'd0; bus.DONE = 1'b0;
        rand_centres();
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        chk("model_cov_2_3", cov(9, 10, 7, 7), 1);
        chk("model_cov_3_3", cov(10, 10, 7, 7), 0);
        chk("model_cov_4_1", cov(11, 8, 7, 7), 0);

        // All points on C1
        for (int k = 0; k < N; k++) pts[k] = 8'h55;
        load(0, N, 1'b0);
        run_frame(5, 5, 0, 0, 3, 1'b0, 1'b0);
        chk("t1_score", SCORE, 40);
        chk("t1_err", ERR, 0);

        // Offsets (0,0),(2,3),(3,3),(4,1) around (7,7)
        pts[0] = 8'h77; pts[1] = 8'hA9; pts[2] = 8'hAA; pts[3] = 8'h8B;
        for (int k = 4; k < N; k++) pts[k] = 8'hF0;
        chk("model_t2", score_of(pts, 7, 7, 7, 7), 2);
        load(0, N, 1'b0);
        run_frame(7, 7, 7, 7, 0, 1'b0, 1'b0);
        chk("t2_score", SCORE, 2);

        // START with 39 loaded, then START alongside the 40th write: both ignored
        for (int k = 0; k < N; k++) pts[k] = 8'($urandom);
        load(0, N - 1, 1'b0);
        START = 1'b1; tick(); START = 1'b0;
        repeat (4) tick();
        chk("t3_busy", BUSY, 0);
        chk("t3_lrst", bus.LRST, 0);
        load(N - 1, 1, 1'b1);
        chk("t3_busy_after_same_cycle_start", BUSY, 0);
        run_frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), 7, 1'b0, 1'b0);

        // Engine never answers
        for (int k = 0; k < N; k++) pts[k] = 8'($urandom);
        load(0, N, 1'b0);
        run_frame(0, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("t4_err", ERR, 1);
        chk("t4_score", SCORE, 0);

        // Next frame clears ERR
        for (int k = 0; k < N; k++) pts[k] = 8'($urandom);
        load(0, N, 1'b0);
        run_frame(3, 4, 12, 11, 2, 1'b0, 1'b0);
        chk("t5_err_cleared", ERR, 0);

        // Reset while streaming point 20
        begin
            int n;
            for (int k = 0; k < N; k++) pts[k] = 8'($urandom);
            load(0, N, 1'b0);
            START = 1'b1; n = cyc; tick(); START = 1'b0;
            while (cyc < n + 22) tick();
            RST = 1'b1;
            tick(); tick();
            RST = 1'b0;
            for (int i = 0; i < 120; i++) begin
                bus.DONE = 1'($urandom_range(0, 1));
                tick();
            end
            bus.DONE = 1'b0;
            chk("t6_ready", bus.LD_READY, 1);
            chk("t6_busy", BUSY, 0);
        end

        // DONE pulse while streaming must be ignored
        for (int k = 0; k < N; k++) pts[k] = 8'($urandom);
        load(0, N, 1'b0);
        run_frame(8, 8, 2, 13, 5, 1'b0, 1'b1);

        // Random frames
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++) pts[k] = 8'($urandom);
            load(0, N, 1'b0);
            run_frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 20), 1'b0, f[0]);
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
